// File: rtl/ddr_mem_responder.sv
// ddr_mem_responder: responder end of the DDR command interface. Commands and
// write beats are queued in registered FIFOs. Each command is served as a
// two-beat line access on a single-port synchronous RAM, and read beats come
// back through a first-word-fall-through read buffer.
//
// Handshake semantics: every queue input is a one-cycle push strobe with no
// ready. The initiator throttles on the registered almost-full flags
// (af_full_o / wb_full_o), and two entries of slack are held back for pushes
// made without checking. A push into a completely full queue is dropped and
// raises overflow_err_o. The read side is valid/pop: read_data_o is valid
// whenever rb_empty_o = 0, and rd_rb_i pops it on the clock edge. Popping an
// empty buffer is ignored and raises underflow_err_o.
//
// state_o encoding (debug): 0 IDLE, 1 WR0, 2 WR1, 3 RD0, 4 RD1.

// Registered FIFO. The head is a plain array read; storage is flushed by pointers.
module ddr_mem_responder_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers and count; reset empties the queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage write. No reset is needed because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

module ddr_mem_responder #(
    parameter int AF_DEPTH = 8,
    parameter int WB_DEPTH = 8,
    parameter int RB_DEPTH = 8,
    parameter int MEM_AW   = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_af_i,
    input  logic [25:0]       af_address_i,
    input  logic              af_read_i,
    output logic              af_full_o,
    input  logic              wr_wb_i,
    input  logic [127:0]      write_data_i,
    output logic              wb_full_o,
    input  logic              rd_rb_i,
    output logic [127:0]      read_data_o,
    output logic              rb_empty_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [127:0]      mem_wdata_o,
    input  logic [127:0]      mem_rdata_i,
    output logic              overflow_err_o,
    output logic              underflow_err_o,
    output logic [2:0]        state_o
);
    localparam int AFC  = $clog2(AF_DEPTH) + 1;
    localparam int WBC  = $clog2(WB_DEPTH) + 1;
    localparam int RBC  = $clog2(RB_DEPTH) + 1;
    localparam int RBC1 = RBC + 1;
    localparam logic [AFC-1:0] AF_ALMOST = AFC'(AF_DEPTH - 2);
    localparam logic [WBC-1:0] WB_ALMOST = WBC'(WB_DEPTH - 2);
    localparam logic [WBC-1:0] WB_LINE   = WBC'(2);
    localparam logic [RBC:0]   RB_LIMIT  = RBC1'(RB_DEPTH - 2);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR0  = 3'd1,
        ST_WR1  = 3'd2,
        ST_RD0  = 3'd3,
        ST_RD1  = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic [MEM_AW-2:0] line_q, line_d;
    logic [RBC-1:0]    inflight_q, inflight_d;
    logic              vld_q;
    logic              ovf_q, udf_q;

    logic [MEM_AW-1:0] af_head;
    logic [AFC-1:0]    af_count;
    logic              af_full_hard;
    logic [127:0]      wb_head;
    logic [WBC-1:0]    wb_count;
    logic              wb_full_hard;
    logic [127:0]      rb_head;
    logic [RBC-1:0]    rb_count;
    logic              unused_rb_full;
    logic              unused_addr_bits;
    logic [RBC:0]      rb_used;

    logic af_pop, wb_pop, rd_issue, mem_en, mem_we, beat;

    // Line bits above the RAM size alias onto lower lines and are never stored.
    assign unused_addr_bits = ^af_address_i[25:MEM_AW-1];

    ddr_mem_responder_fifo #(.W(MEM_AW), .DEPTH(AF_DEPTH), .CW(AFC)) u_af (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (wr_af_i),
        .pop_i  (af_pop),
        .data_i ({af_read_i, af_address_i[MEM_AW-2:0]}),
        .data_o (af_head),
        .count_o(af_count),
        .full_o (af_full_hard)
    );

    ddr_mem_responder_fifo #(.W(128), .DEPTH(WB_DEPTH), .CW(WBC)) u_wb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (wr_wb_i),
        .pop_i  (wb_pop),
        .data_i (write_data_i),
        .data_o (wb_head),
        .count_o(wb_count),
        .full_o (wb_full_hard)
    );

    ddr_mem_responder_fifo #(.W(128), .DEPTH(RB_DEPTH), .CW(RBC)) u_rb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (vld_q),
        .pop_i  (rd_rb_i),
        .data_i (mem_rdata_i),
        .data_o (rb_head),
        .count_o(rb_count),
        .full_o (unused_rb_full)
    );

    // Buffered beats plus beats still in the RAM pipe must leave room for a whole line.
    assign rb_used = {1'b0, rb_count} + {1'b0, inflight_q};

    // Next state and RAM strobes. The AF head is never bypassed, so command order is kept.
    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        af_pop   = 1'b0;
        wb_pop   = 1'b0;
        rd_issue = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        beat     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (af_count != '0) begin
                    if (!af_head[MEM_AW-1]) begin
                        if (wb_count >= WB_LINE) begin
                            af_pop  = 1'b1;
                            line_d  = af_head[MEM_AW-2:0];
                            state_d = ST_WR0;
                        end
                    end else if (rb_used <= RB_LIMIT) begin
                        af_pop   = 1'b1;
                        rd_issue = 1'b1;
                        line_d   = af_head[MEM_AW-2:0];
                        state_d  = ST_RD0;
                    end
                end
            end
            ST_WR0: begin
                mem_en  = 1'b1;
                mem_we  = 1'b1;
                wb_pop  = 1'b1;
                state_d = ST_WR1;
            end
            ST_WR1: begin
                mem_en  = 1'b1;
                mem_we  = 1'b1;
                wb_pop  = 1'b1;
                beat    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RD0: begin
                mem_en  = 1'b1;
                state_d = ST_RD1;
            end
            ST_RD1: begin
                mem_en  = 1'b1;
                beat    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Inflight count: +2 when a read line is issued, -1 as each beat lands in the RB.
    always_comb begin
        inflight_d = inflight_q;
        if (rd_issue && !vld_q)     inflight_d = inflight_q + RBC'(2);
        else if (rd_issue && vld_q) inflight_d = inflight_q + RBC'(1);
        else if (vld_q)             inflight_d = inflight_q - RBC'(1);
    end

    // Control registers. Reset drops any RAM data still in the valid pipe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            line_q     <= '0;
            inflight_q <= '0;
            vld_q      <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            inflight_q <= inflight_d;
            vld_q      <= mem_en && !mem_we;
            ovf_q      <= ovf_q || (wr_af_i && af_full_hard) || (wr_wb_i && wb_full_hard);
            udf_q      <= udf_q || (rd_rb_i && (rb_count == '0));
        end
    end

    assign mem_en_o        = mem_en;
    assign mem_we_o        = mem_we;
    assign mem_addr_o      = mem_en ? {line_q, beat} : '0;
    assign mem_wdata_o     = mem_we ? wb_head : '0;
    assign af_full_o       = (af_count >= AF_ALMOST);
    assign wb_full_o       = (wb_count >= WB_ALMOST);
    assign rb_empty_o      = (rb_count == '0);
    assign read_data_o     = rb_empty_o ? '0 : rb_head;
    assign overflow_err_o  = ovf_q;
    assign underflow_err_o = udf_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_ddr_mem_responder.sv
// Testbench for ddr_mem_responder: a RAM model on the memory port, directed
// scenarios for latency, flow control and errors, and a random command mix
// checked against a line-level reference memory.
module tb_ddr_mem_responder;
    localparam int AF_DEPTH = 8;
    localparam int WB_DEPTH = 8;
    localparam int RB_DEPTH = 8;
    localparam int MEM_AW   = 12;
    localparam int WORDS    = 1 << MEM_AW;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD1  = 3'd4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_af = 1'b0;
    logic [25:0]       af_address = '0;
    logic              af_read = 1'b0;
    logic              af_full;
    logic              wr_wb = 1'b0;
    logic [127:0]      write_data = '0;
    logic              wb_full;
    logic              rd_rb = 1'b0;
    logic [127:0]      read_data;
    logic              rb_empty;
    logic              mem_en, mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata = '0;
    logic              overflow_err, underflow_err;
    logic [2:0]        state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q[$];
    logic [127:0] wb_pend[$];
    logic [12:0]  addr_log[$];
    int rd_beats = 0;
    int wr_beats = 0;

    logic [127:0] ram       [WORDS];
    logic [127:0] model_mem [WORDS];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ddr_mem_responder #(
        .AF_DEPTH(AF_DEPTH), .WB_DEPTH(WB_DEPTH), .RB_DEPTH(RB_DEPTH), .MEM_AW(MEM_AW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wr_af_i        (wr_af),
        .af_address_i   (af_address),
        .af_read_i      (af_read),
        .af_full_o      (af_full),
        .wr_wb_i        (wr_wb),
        .write_data_i   (write_data),
        .wb_full_o      (wb_full),
        .rd_rb_i        (rd_rb),
        .read_data_o    (read_data),
        .rb_empty_o     (rb_empty),
        .mem_en_o       (mem_en),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .overflow_err_o (overflow_err),
        .underflow_err_o(underflow_err),
        .state_o        (state)
    );

    // Synchronous single-port RAM: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // Memory-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && mem_en) begin
            if (mem_we) wr_beats += 1;
            else        rd_beats += 1;
            addr_log.push_back({mem_we, mem_addr});
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input int unsigned line, input int unsigned beat);
        return int'((line * 2 + beat) % WORDS);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- drivers ----------------
    // One cycle of stimulus, applied at a falling edge; RB pops are scoreboarded here.
    task automatic cycle_drive(input bit af_v, input bit af_rd, input int unsigned line,
                               input bit wb_v, input bit pop);
        wr_af      = af_v;
        af_read    = af_rd;
        af_address = line[25:0];
        wr_wb      = wb_v && (wb_pend.size() != 0);
        write_data = '0;
        if (wr_wb) write_data = wb_pend.pop_front();
        rd_rb = pop;
        if (pop && !rb_empty) begin
            check_eq("rb_exp_avail", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) check_eq("rb_data", read_data, exp_q.pop_front());
        end
        @(negedge clk);
        wr_af = 1'b0; af_read = 1'b0; af_address = '0;
        wr_wb = 1'b0; write_data = '0; rd_rb = 1'b0;
    endtask

    task automatic issue_write(input int unsigned line, input logic [127:0] d0,
                               input logic [127:0] d1, input bit wb_v, input bit pop);
        model_mem[widx(line, 0)] = d0;
        model_mem[widx(line, 1)] = d1;
        wb_pend.push_back(d0);
        wb_pend.push_back(d1);
        cycle_drive(1'b1, 1'b0, line, wb_v, pop);
    endtask

    task automatic issue_read(input int unsigned line, input bit wb_v, input bit pop);
        exp_q.push_back(model_mem[widx(line, 0)]);
        exp_q.push_back(model_mem[widx(line, 1)]);
        cycle_drive(1'b1, 1'b1, line, wb_v, pop);
    endtask

    task automatic idle(input int n, input bit wb_v, input bit pop_en);
        for (int i = 0; i < n; i++) cycle_drive(1'b0, 1'b0, 0, wb_v, pop_en && !rb_empty);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || wb_pend.size() != 0) && k < budget) begin
            cycle_drive(1'b0, 1'b0, 0, !wb_full, !rb_empty);
            k++;
        end
        check_eq("drain_left", 128'(exp_q.size() + wb_pend.size()), 128'd0);
        idle(10, 1'b0, 1'b0);
        check_eq("drain_rb_empty", 128'(rb_empty), 128'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        wb_pend.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int k;
        for (int i = 0; i < WORDS; i++) begin
            ram[i] = '0;
            model_mem[i] = '0;
        end

        // Reset values, during and after reset
        @(negedge clk);
        check_eq("rst_af_full", 128'(af_full), 128'd0);
        check_eq("rst_wb_full", 128'(wb_full), 128'd0);
        check_eq("rst_rb_empty", 128'(rb_empty), 128'd1);
        check_eq("rst_read_data", read_data, 128'd0);
        check_eq("rst_mem_en", 128'(mem_en), 128'd0);
        check_eq("rst_mem_we", 128'(mem_we), 128'd0);
        check_eq("rst_mem_addr", 128'(mem_addr), 128'd0);
        check_eq("rst_mem_wdata", mem_wdata, 128'd0);
        check_eq("rst_ovf", 128'(overflow_err), 128'd0);
        check_eq("rst_udf", 128'(underflow_err), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_state", 128'(state), 128'(ST_IDLE));
        check_eq("post_rst_rb_empty", 128'(rb_empty), 128'd1);

        // Directed write then read of line 0x10, with read latency
        addr_log.delete();
        issue_write(32'h10, {32{4'hA}}, {32{4'h5}}, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b0);
        idle(6, 1'b0, 1'b0);
        issue_read(32'h10, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        check_eq("rd_lat_cyc3_empty", 128'(rb_empty), 128'd1);
        idle(1, 1'b0, 1'b0);
        check_eq("rd_lat_cyc4_empty", 128'(rb_empty), 128'd0);
        check_eq("rd_beat0", read_data, {32{4'hA}});
        cycle_drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        check_eq("rd_beat1_avail", 128'(rb_empty), 128'd0);
        cycle_drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(2, 1'b0, 1'b0);
        check_eq("addr_log_len", 128'(addr_log.size()), 128'd4);
        check_eq("addr_seq0", 128'(addr_log[0]), 128'h1020);
        check_eq("addr_seq1", 128'(addr_log[1]), 128'h1021);
        check_eq("addr_seq2", 128'(addr_log[2]), 128'h0020);
        check_eq("addr_seq3", 128'(addr_log[3]), 128'h0021);

        // Write command arrives before its data; a read queues behind it
        addr_log.delete();
        issue_write(32'h33, rand128(), rand128(), 1'b0, 1'b0);
        issue_read(32'h33, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check_eq("late_wb_no_en", 128'(mem_en), 128'd0);
            idle(1, 1'b0, 1'b0);
        end
        idle(1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_eq("one_beat_no_en", 128'(mem_en), 128'd0);
            idle(1, 1'b0, 1'b0);
        end
        idle(1, 1'b1, 1'b0);
        drain(100);
        check_eq("late_log_len", 128'(addr_log.size()), 128'd4);
        check_eq("late_seq0", 128'(addr_log[0]), 128'h1066);
        check_eq("late_seq1", 128'(addr_log[1]), 128'h1067);
        check_eq("late_seq2", 128'(addr_log[2]), 128'h0066);
        check_eq("late_seq3", 128'(addr_log[3]), 128'h0067);

        // Eight reads with no pops: RB back-pressure stalls the fifth
        for (int i = 0; i < 4; i++) issue_write(32'h40 + i, rand128(), rand128(), 1'b0, 1'b0);
        drain(200);
        base = rd_beats;
        for (int i = 0; i < 8; i++) issue_read(32'h40 + (i % 4), 1'b0, 1'b0);
        idle(40, 1'b0, 1'b0);
        check_eq("rb_bp_beats", 128'(rd_beats - base), 128'd8);
        check_eq("rb_bp_state", 128'(state), 128'(ST_IDLE));
        check_eq("rb_bp_not_empty", 128'(rb_empty), 128'd0);
        cycle_drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(10, 1'b0, 1'b0);
        check_eq("rb_bp_one_pop", 128'(rd_beats - base), 128'd8);
        cycle_drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(10, 1'b0, 1'b0);
        check_eq("rb_bp_two_pops", 128'(rd_beats - base), 128'd10);
        drain(500);
        check_eq("rb_bp_ovf", 128'(overflow_err), 128'd0);

        // Random command mix against the reference memory
        for (int c = 0; c < 800; c++) begin
            bit av, rd, wv, pp;
            int unsigned line;
            av = !af_full && ($urandom_range(0, 3) == 0);
            rd = 1'($urandom_range(0, 1));
            wv = !wb_full && ($urandom_range(0, 2) != 0);
            pp = !rb_empty && ($urandom_range(0, 1) == 1);
            line = $urandom_range(0, 15) + ($urandom_range(0, 3) << 11);
            if (av && rd)  issue_read(line, wv, pp);
            else if (av)   issue_write(line, rand128(), rand128(), wv, pp);
            else           cycle_drive(1'b0, 1'b0, 0, wv, pp);
        end
        drain(3000);
        check_eq("rand_ovf", 128'(overflow_err), 128'd0);
        check_eq("rand_udf", 128'(underflow_err), 128'd0);

        // Pop of an empty read buffer
        check_eq("udf_pre_state", 128'(state), 128'(ST_IDLE));
        cycle_drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        check_eq("udf_flag", 128'(underflow_err), 128'd1);
        check_eq("udf_state", 128'(state), 128'(ST_IDLE));
        check_eq("udf_rb_empty", 128'(rb_empty), 128'd1);

        // Address FIFO fill: writes stall with no WB data
        for (int i = 0; i < 5; i++) cycle_drive(1'b1, 1'b0, 7, 1'b0, 1'b0);
        check_eq("af_full_at5", 128'(af_full), 128'd0);
        cycle_drive(1'b1, 1'b0, 7, 1'b0, 1'b0);
        check_eq("af_full_at6", 128'(af_full), 128'd1);
        cycle_drive(1'b1, 1'b0, 7, 1'b0, 1'b0);
        cycle_drive(1'b1, 1'b0, 7, 1'b0, 1'b0);
        check_eq("ovf_at8", 128'(overflow_err), 128'd0);
        cycle_drive(1'b1, 1'b0, 7, 1'b0, 1'b0);
        check_eq("ovf_at9", 128'(overflow_err), 128'd1);
        check_eq("ovf_no_en", 128'(mem_en), 128'd0);
        do_reset();
        check_eq("ovf_rst_clear", 128'(overflow_err), 128'd0);
        check_eq("udf_rst_clear", 128'(underflow_err), 128'd0);
        check_eq("af_rst_clear", 128'(af_full), 128'd0);

        // Reset in RD1 with a beat in flight
        issue_read(32'h41, 1'b0, 1'b0);
        k = 0;
        while (state != ST_RD1 && k < 10) begin
            idle(1, 1'b0, 1'b0);
            k++;
        end
        check_eq("reach_rd1", 128'(state), 128'(ST_RD1));
        do_reset();
        check_eq("rd1_rst_state", 128'(state), 128'(ST_IDLE));
        check_eq("rd1_rst_af_full", 128'(af_full), 128'd0);
        for (int i = 0; i < 8; i++) begin
            check_eq("rd1_rst_rb_empty", 128'(rb_empty), 128'd1);
            idle(1, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
